// File: rtl/dmem_responder_pkg.sv
// Shared CPU package: RV32 load/store width codes, responder FSM states
// and small decode helpers.
package dmem_responder_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Unsigned widths exist only for loads.
  function automatic logic memop_legal(input logic we, input logic [2:0] memop);
    logic ok;
    case (memop)
      MEMOP_B, MEMOP_H, MEMOP_W: ok = 1'b1;
      MEMOP_BU, MEMOP_HU:        ok = ~we;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic memop_misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
    logic bad;
    case (memop)
      MEMOP_H, MEMOP_HU: bad = addr_lo[0];
      MEMOP_W:           bad = (addr_lo != 2'b00);
      default:           bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and load
// extraction with sign or zero extension.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] rshift_s;

  assign rshift_s = rword >> {addr_lo, 3'b000};

  // Store side: replicate data so every candidate lane carries it.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0000_0000;
    case (memop)
      MEMOP_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      MEMOP_H: begin
        byte_en    = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      MEMOP_W: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0000_0000;
      end
    endcase
  end

  // Load side: aligned accesses only, so the lane shift suffices.
  always_comb begin
    rdata_ext = 32'h0000_0000;
    case (memop)
      MEMOP_B:  rdata_ext = {{24{rshift_s[7]}}, rshift_s[7:0]};
      MEMOP_BU: rdata_ext = {24'h00_0000, rshift_s[7:0]};
      MEMOP_H:  rdata_ext = {{16{rshift_s[15]}}, rshift_s[15:0]};
      MEMOP_HU: rdata_ext = {16'h0000, rshift_s[15:0]};
      MEMOP_W:  rdata_ext = rshift_s;
      default:  rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, fixed wait states,
// response held until accepted.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_memop,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        accept_s, commit_s;
  logic        we_r;
  logic [31:0] addr_r, wdata_r;
  logic [2:0]  memop_r;
  logic        op_we_s;
  logic [31:0] op_addr_s, op_wdata_s;
  logic [2:0]  op_memop_s;
  logic        err_s;
  logic [3:0]  byte_en_s;
  logic [31:0] wdata_lane_s, rdata_ext_s, rword_s;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  // With no wait states the commit happens on the accept edge, so the
  // operation fields come straight from the request port in IDLE.
  assign op_we_s    = (state_r == ST_IDLE) ? req_we    : we_r;
  assign op_addr_s  = (state_r == ST_IDLE) ? req_addr  : addr_r;
  assign op_wdata_s = (state_r == ST_IDLE) ? req_wdata : wdata_r;
  assign op_memop_s = (state_r == ST_IDLE) ? req_memop : memop_r;

  assign err_s = ~memop_legal(op_we_s, op_memop_s)
               | memop_misaligned(op_memop_s, op_addr_s[1:0])
               | (op_addr_s[31:2] >= 30'(DEPTH_WORDS));

  assign rword_s = mem_r[op_addr_s[AW+1:2]];

  dmem_lane_align u_lane_align (
    .memop      (op_memop_s),
    .addr_lo    (op_addr_s[1:0]),
    .wdata      (op_wdata_s),
    .rword      (rword_s),
    .byte_en    (byte_en_s),
    .wdata_lane (wdata_lane_s),
    .rdata_ext  (rdata_ext_s)
  );

  // FSM state and wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; commit_s marks the edge that enters RESP.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          cnt_s    = 4'd0;
          if (NO_WAIT) begin
            state_s  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_s  = ST_RESP;
          cnt_s    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Request field latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      memop_r      <= 3'b000;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        memop_r <= req_memop;
      end
      if (commit_s) begin
        resp_err_r   <= err_s;
        resp_rdata_r <= (err_s | op_we_s) ? 32'h0000_0000 : rdata_ext_s;
      end
    end
  end

  // Storage is never reset; a reset edge cancels a pending store.
  always_ff @(posedge clk) begin
    if (commit_s && !rst && op_we_s && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[op_addr_s[AW+1:2]][8*i +: 8] <= wdata_lane_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = (state_r == ST_RESP);
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, added wait states per access (legal range 0..15).
REQ-003 SHALL have port clk input 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst input 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid input 1: initiator presents a request.
REQ-006 SHALL have port req_ready output 1: responder can accept a request.
REQ-007 SHALL have port req_we input 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr input 32: byte address.
REQ-009 SHALL have port req_wdata input 32: store data, right-aligned.
REQ-010 SHALL have port req_memop input 3: RV32 funct3 width code.
REQ-011 SHALL have port resp_valid output 1: response available.
REQ-012 SHALL have port resp_ready input 1: initiator accepts the response.
REQ-013 SHALL have port resp_rdata output 32: load data, extended per memop; 0 for stores and errors.
REQ-014 SHALL have port resp_err output 1: access was misaligned, out of range, or an illegal memop.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 SHALL accept on req_valid&&req_ready, latching we/addr/wdata/memop; next state WAIT, or RESP when WAIT_CYCLES=0.
REQ-017 SHALL count WAIT_CYCLES cycles in WAIT, then enter RESP; resp_valid rises exactly WAIT_CYCLES+1 cycles after acceptance.
REQ-018 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE; no request is accepted in the same cycle.
REQ-019 SHALL decode memop: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw; any other code sets resp_err.
REQ-020 SHALL flag misalignment: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-021 SHALL flag out-of-range when addr[31:2] >= DEPTH_WORDS.
REQ-022 SHALL commit stores on the WAIT->RESP (or IDLE->RESP) transition, writing only the addressed byte lanes; errored stores write nothing.
REQ-023 SHALL sample load data on the same transition: sign-extend for lb/lh, zero-extend for lbu/lhu, selecting the lane by addr[1:0].
REQ-024 SHALL ignore req_valid, and leave latched fields unchanged, while in WAIT or RESP.

Reset
REQ-025 SHALL on rst force state IDLE, wait counter 0, resp_valid 0, resp_rdata 0, resp_err 0 and req_ready 1 in the following cycle.
REQ-026 SHALL, on rst during WAIT, discard the pending store so memory is unchanged; rst during RESP drops the response.
REQ-027 SHALL NOT reset storage contents.

Structure
REQ-028 SHALL place the memop encodings and the FSM state enum in the shared CPU package, which the fetch/control logic also uses.
REQ-029 SHALL use one combinational sub-module, dmem_lane_align, for store byte-enable/merge and load extraction/extension.

Verification
REQ-030 SHALL cover: sw 0xDEADBEEF @0x10, then lw @0x10 -> resp_rdata 0xDEADBEEF, err 0, resp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
REQ-031 SHALL cover: after REQ-030, lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; sb 0x55 @0x11, then lw @0x10 -> 0xDEAD55EF.
REQ-032 SHALL cover: lw @0x12 and sh @0x11 -> err 1, rdata 0, and word @0x10 unchanged.
REQ-033 SHALL cover: lw @(DEPTH_WORDS*4) -> err 1; memop 011 -> err 1.
REQ-034 SHALL cover: resp_ready held low 5 cycles -> resp_valid/resp_rdata stable throughout, req_ready 0; a req_valid pulse during RESP is ignored.
REQ-035 SHALL cover: sw 0x12345678 @0x20 with rst asserted 1 cycle after accept -> IDLE next cycle, later lw @0x20 returns the prior value.
